// File: rtl/key_switch_conditioner_pkg.sv
// Shared types and defaults for the lab7 KEY/SW input conditioning path.
package lab7_input_pkg;

   typedef enum logic {DB_STABLE, DB_PENDING} db_state_t;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/key_switch_conditioner_debounce_bit.sv
// One-bit conditioner: 2-flop synchronizer, stability FSM + counter, registered edge strobes.
module debounce_bit
   import lab7_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic        RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [1:0]       sync_q;
   logic             synced;
   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   assign synced = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= {2{RESET_LEVEL}};
         state_q <= DB_STABLE;
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // The terminal-count test comes before the increment, so the counter never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         DB_STABLE: begin
            cnt_d = '0;
            if (synced != level_q) begin
               state_d = DB_PENDING;
               cnt_d   = CNT_W'(1);
            end
         end
         DB_PENDING: begin
            if (synced == level_q) begin
               state_d = DB_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = DB_STABLE;
               cnt_d   = '0;
               level_d = ~level_q;
               rise_d  = ~level_q;
               fall_d  = level_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = DB_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/key_switch_conditioner.sv
// Synchronizes and debounces KEY[3:1] and SW[7:0] ahead of the lab7 SoC PIO exports.
module key_switch_conditioner
   import lab7_input_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = 3,
   parameter int unsigned NUM_SW          = 8,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [NUM_KEYS-1:0] key_raw_n,
   input  logic [NUM_SW-1:0]   sw_raw,
   output logic [NUM_KEYS-1:0] key_level_n,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_SW-1:0]   sw_level
);

   // Keys idle high, so a press is a falling edge of the debounced level.
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b1)
      ) u_key_db (
         .clk   (clk_clk),
         .rst_n (reset_reset_n),
         .raw   (key_raw_n[i]),
         .level (key_level_n[i]),
         .rise  (key_release[i]),
         .fall  (key_press[i])
      );
   end

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b0)
      ) u_sw_db (
         .clk   (clk_clk),
         .rst_n (reset_reset_n),
         .raw   (sw_raw[i]),
         .level (sw_level[i]),
         .rise  (),
         .fall  ()
      );
   end

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Directed bench for key_switch_conditioner with a short debounce window.
module tb_key_switch_conditioner;

   localparam int unsigned NK = 3;
   localparam int unsigned NS = 8;
   localparam int unsigned DC = 4;

   logic          clk_clk;
   logic          reset_reset_n;
   logic [NK-1:0] key_raw_n;
   logic [NS-1:0] sw_raw;
   logic [NK-1:0] key_level_n;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic [NS-1:0] sw_level;

   int compared;
   int mismatched;

   key_switch_conditioner #(
      .NUM_KEYS        (NK),
      .NUM_SW          (NS),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .key_raw_n     (key_raw_n),
      .sw_raw        (sw_raw),
      .key_level_n   (key_level_n),
      .key_press     (key_press),
      .key_release   (key_release),
      .sw_level      (sw_level)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Advance one active edge and sample just after it.
   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [NK-1:0] lvl, input logic [NK-1:0] prs,
                            input logic [NK-1:0] rel, input logic [NS-1:0] sw);
      check({tag, ".key_level_n"}, 32'(key_level_n), 32'(lvl));
      check({tag, ".key_press"}, 32'(key_press), 32'(prs));
      check({tag, ".key_release"}, 32'(key_release), 32'(rel));
      check({tag, ".sw_level"}, 32'(sw_level), 32'(sw));
   endtask

   initial begin
      logic [NK-1:0] lvl;
      logic [NK-1:0] prs;
      logic [NK-1:0] rel;
      logic [NS-1:0] swe;
      compared      = 0;
      mismatched    = 0;
      reset_reset_n = 1'b0;
      key_raw_n     = 3'b111;
      sw_raw        = 8'h00;
      tick();
      tick();
      check_all("reset_init", 3'b111, 3'b000, 3'b000, 8'h00);
      reset_reset_n = 1'b1;
      repeat (3) tick();
      check_all("idle", 3'b111, 3'b000, 3'b000, 8'h00);

      // Clean press on key 0: edge 0 is the first edge after the change.
      key_raw_n[0] = 1'b0;
      for (int e = 0; e <= 7; e++) begin
         tick();
         lvl = (e >= 6) ? 3'b110 : 3'b111;
         prs = (e == 6) ? 3'b001 : 3'b000;
         check_all($sformatf("press_k0_e%0d", e), lvl, prs, 3'b000, 8'h00);
      end

      // Release of key 0.
      key_raw_n[0] = 1'b1;
      for (int e = 0; e <= 7; e++) begin
         tick();
         lvl = (e >= 6) ? 3'b111 : 3'b110;
         rel = (e == 6) ? 3'b001 : 3'b000;
         check_all($sformatf("release_k0_e%0d", e), lvl, 3'b000, rel, 8'h00);
      end

      // Bounce on key 1: low 3 cycles, high 1, then low held; final fall precedes edge 4.
      for (int e = 0; e <= 11; e++) begin
         if (e == 0) key_raw_n[1] = 1'b0;
         if (e == 3) key_raw_n[1] = 1'b1;
         if (e == 4) key_raw_n[1] = 1'b0;
         tick();
         lvl = (e >= 10) ? 3'b101 : 3'b111;
         prs = (e == 10) ? 3'b010 : 3'b000;
         check_all($sformatf("bounce_k1_e%0d", e), lvl, prs, 3'b000, 8'h00);
      end
      key_raw_n[1] = 1'b1;
      repeat (8) tick();
      check_all("bounce_k1_restored", 3'b111, 3'b000, 3'b000, 8'h00);

      // Switches accept a multi-bit change together.
      sw_raw = 8'hA5;
      for (int e = 0; e <= 6; e++) begin
         tick();
         swe = (e >= 6) ? 8'hA5 : 8'h00;
         check({"sw_a5_e", $sformatf("%0d", e)}, 32'(sw_level), 32'(swe));
      end
      // One-cycle dip on sw_raw[0] must be rejected.
      sw_raw = 8'hA4;
      tick();
      sw_raw = 8'hA5;
      for (int e = 0; e <= 9; e++) begin
         tick();
         check($sformatf("sw_glitch_e%0d", e), 32'(sw_level), 32'h0000_00A5);
      end

      // Key 2 pending, reset asserted at edge 3 and released at edge 5.
      key_raw_n[2] = 1'b0;
      repeat (3) tick();
      @(posedge clk_clk);
      #1;
      reset_reset_n = 1'b0;
      #1;
      check_all("reset_mid_pending", 3'b111, 3'b000, 3'b000, 8'h00);
      tick();
      tick();
      check_all("reset_held", 3'b111, 3'b000, 3'b000, 8'h00);
      reset_reset_n = 1'b1;
      for (int e = 0; e <= 7; e++) begin
         tick();
         lvl = (e >= 6) ? 3'b011 : 3'b111;
         prs = (e == 6) ? 3'b100 : 3'b000;
         swe = (e >= 6) ? 8'hA5 : 8'h00;
         check_all($sformatf("post_reset_k2_e%0d", e), lvl, prs, 3'b000, swe);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
